// File: rtl/wb_trace_capture_pkg.sv
// Trace record layout shared by the write-back trace capture block.
// Record is packed {seq, pc, reg, value} with value in the low bits.
package wb_trace_capture_pkg;

  localparam int PC_W  = 32;
  localparam int REG_W = 5;
  localparam int VAL_W = 32;

  localparam int SEQ_W_DEFAULT = 16;

  // Bit offsets of each field inside the packed record. Seq sits on top,
  // so these do not depend on the sequence width.
  localparam int VAL_LSB = 0;
  localparam int REG_LSB = VAL_LSB + VAL_W;
  localparam int PC_LSB  = REG_LSB + REG_W;
  localparam int SEQ_LSB = PC_LSB + PC_W;

  function automatic int trace_rec_w(input int seq_w);
    return seq_w + PC_W + REG_W + VAL_W;
  endfunction

  localparam int TRACE_REC_W = trace_rec_w(SEQ_W_DEFAULT);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage; head is read straight from
// the storage array so a write shows up at dout one cycle later.
module trace_fifo #(
  parameter int WIDTH = 85,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = level_q;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // unreachable because the level counter marks them empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Captures debug write-back events into a FIFO and streams tagged records
// to a trace sink. Define WB_TRACE_X0_FILTER_EN to ignore x0 writes.
module wb_trace_capture
  import wb_trace_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     clear_stats,
  input  logic                     debug_wb_have_inst,
  input  logic [31:0]              debug_wb_pc,
  input  logic                     debug_wb_ena,
  input  logic [4:0]               debug_wb_reg,
  input  logic [31:0]              debug_wb_value,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_reg,
  output logic [31:0]              trace_value,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [31:0]              inst_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int REC_W = trace_rec_w(SEQ_W);

  logic             reg_ok;
  logic             wb_event;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;

  logic [SEQ_W-1:0]  seq_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;
  logic [31:0]       inst_q;

`ifdef WB_TRACE_X0_FILTER_EN
  assign reg_ok = (debug_wb_reg != 5'd0);
`else
  assign reg_ok = 1'b1;
`endif

  assign wb_event = capture_en & debug_wb_ena & reg_ok;
  assign pop      = trace_valid & trace_ready;
  assign accept   = wb_event & (~fifo_full | pop);
  assign drop     = wb_event & fifo_full & ~pop;
  assign rec_in   = {seq_q, debug_wb_pc, debug_wb_reg, debug_wb_value};

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Fields read zero whenever nothing is queued, so reset and drain look alike.
  assign trace_valid = ~fifo_empty;
  assign trace_seq   = trace_valid ? rec_out[SEQ_LSB +: SEQ_W] : '0;
  assign trace_pc    = trace_valid ? rec_out[PC_LSB  +: PC_W]  : '0;
  assign trace_reg   = trace_valid ? rec_out[REG_LSB +: REG_W] : '0;
  assign trace_value = trace_valid ? rec_out[VAL_LSB +: VAL_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if (wb_event) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  // Statistics: clear_stats wins over any same-cycle increment or drop.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
      inst_q     <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (capture_en && debug_wb_have_inst) inst_q <= inst_q + 32'd1;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign inst_cnt = inst_q;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed self-checking bench for wb_trace_capture (default parameters).
module tb_wb_trace_capture;

  logic        clk;
  logic        rst;
  logic        capture_en;
  logic        clear_stats;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;
  logic        trace_valid;
  logic        trace_ready;
  logic [15:0] trace_seq;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_value;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [31:0] inst_cnt;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

`ifdef WB_TRACE_X0_FILTER_EN
  localparam int X0_KEPT = 1;
`else
  localparam int X0_KEPT = 2;
`endif

  wb_trace_capture dut (
    .clk                (clk),
    .rst                (rst),
    .capture_en         (capture_en),
    .clear_stats        (clear_stats),
    .debug_wb_have_inst (debug_wb_have_inst),
    .debug_wb_pc        (debug_wb_pc),
    .debug_wb_ena       (debug_wb_ena),
    .debug_wb_reg       (debug_wb_reg),
    .debug_wb_value     (debug_wb_value),
    .trace_valid        (trace_valid),
    .trace_ready        (trace_ready),
    .trace_seq          (trace_seq),
    .trace_pc           (trace_pc),
    .trace_reg          (trace_reg),
    .trace_value        (trace_value),
    .overflow           (overflow),
    .drop_cnt           (drop_cnt),
    .inst_cnt           (inst_cnt),
    .fifo_level         (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic ena, input logic [4:0] r,
                          input logic [31:0] pc, input logic [31:0] v);
    debug_wb_ena   = ena;
    debug_wb_reg   = r;
    debug_wb_pc    = pc;
    debug_wb_value = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; capture_en = 1'b1; clear_stats = 1'b0; debug_wb_have_inst = 1'b0;
    trace_ready = 1'b0;
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    do_reset();

    check("rst_valid",    64'(trace_valid), 64'd0);
    check("rst_level",    64'(fifo_level),  64'd0);
    check("rst_overflow", 64'(overflow),    64'd0);
    check("rst_drop",     64'(drop_cnt),    64'd0);
    check("rst_inst",     64'(inst_cnt),    64'd0);
    check("rst_fields",   64'({trace_seq, trace_reg} | 21'(trace_pc) | 21'(trace_value)), 64'd0);

    // Three events with ready high: each record appears one cycle later.
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ev(1'b1, 5'd5, 32'h100 + 32'(4 * i), 32'hA + 32'(i));
      cycle();
      check("t1_valid", 64'(trace_valid), 64'd1);
      check("t1_seq",   64'(trace_seq),   64'(i));
      check("t1_pc",    64'(trace_pc),    64'h100 + 64'(4 * i));
      check("t1_reg",   64'(trace_reg),   64'd5);
      check("t1_value", 64'(trace_value), 64'hA + 64'(i));
      check("t1_level", 64'(fifo_level),  64'd1);
    end
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    check("t1_empty", 64'(trace_valid), 64'd0);
    check("t1_level0", 64'(fifo_level), 64'd0);

    // Fill to 16 with the sink stalled, then overflow once.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_ev(1'b1, 5'd3, 32'h200 + 32'(4 * i), 32'(i));
      cycle();
    end
    check("t2_full_level", 64'(fifo_level), 64'd16);
    check("t2_no_ovf_yet", 64'(overflow),   64'd0);
    drive_ev(1'b1, 5'd3, 32'h240, 32'd16);
    cycle();
    check("t2_level_held", 64'(fifo_level), 64'd16);
    check("t2_overflow",   64'(overflow),   64'd1);
    check("t2_drop_cnt",   64'(drop_cnt),   64'd1);
    check("t2_head_stable", 64'(trace_seq), 64'd0);
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_seq", 64'(trace_seq), 64'(i));
      check("t2_drain_pc",  64'(trace_pc),  64'h200 + 64'(4 * i));
      cycle();
    end
    check("t2_drained", 64'(trace_valid), 64'd0);
    drive_ev(1'b1, 5'd3, 32'h300, 32'h33);
    cycle();
    check("t2_gap_seq", 64'(trace_seq), 64'd17);
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    check("t2_level0", 64'(fifo_level), 64'd0);

    // Full FIFO with a same-cycle pop: the event is accepted, not dropped.
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    check("t3_clr_drop", 64'(drop_cnt), 64'd0);
    check("t3_clr_ovf",  64'(overflow), 64'd0);
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_ev(1'b1, 5'd4, 32'h400 + 32'(4 * i), 32'(i));
      cycle();
    end
    trace_ready = 1'b1;
    drive_ev(1'b1, 5'd4, 32'h500, 32'h50);
    cycle();
    check("t3_level",    64'(fifo_level), 64'd16);
    check("t3_drop",     64'(drop_cnt),   64'd0);
    check("t3_overflow", 64'(overflow),   64'd0);
    check("t3_head",     64'(trace_seq),  64'd19);
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 15; i++) cycle();
    check("t3_last_seq",   64'(trace_seq),   64'd34);
    check("t3_last_value", 64'(trace_value), 64'h50);
    cycle();
    check("t3_level0", 64'(fifo_level), 64'd0);

    // x0 write followed by a normal write; seq counter now at 35.
    trace_ready = 1'b0;
    drive_ev(1'b1, 5'd0, 32'h600, 32'h55);
    cycle();
    drive_ev(1'b1, 5'd7, 32'h604, 32'h77);
    cycle();
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
`ifdef WB_TRACE_X0_FILTER_EN
    check("t4_level", 64'(fifo_level),  64'd1);
    check("t4_seq",   64'(trace_seq),   64'd35);
    check("t4_reg",   64'(trace_reg),   64'd7);
    check("t4_value", 64'(trace_value), 64'h77);
`else
    check("t4_level", 64'(fifo_level),  64'd2);
    check("t4_seq",   64'(trace_seq),   64'd35);
    check("t4_reg",   64'(trace_reg),   64'd0);
    check("t4_value", 64'(trace_value), 64'h55);
`endif

    // Fill, drop twice, count 10 instructions, then clear with an 11th.
    for (int i = 0; i < 16 - X0_KEPT + 2; i++) begin
      drive_ev(1'b1, 5'd9, 32'h700 + 32'(4 * i), 32'(i));
      cycle();
    end
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    check("t5_drop2", 64'(drop_cnt), 64'd2);
    check("t5_ovf",   64'(overflow), 64'd1);
    debug_wb_have_inst = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("t5_inst10", 64'(inst_cnt), 64'd10);
    clear_stats = 1'b1;
    drive_ev(1'b1, 5'd9, 32'h800, 32'h88);
    cycle();
    clear_stats = 1'b0;
    debug_wb_have_inst = 1'b0;
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    check("t5_inst0",  64'(inst_cnt),   64'd0);
    check("t5_ovf0",   64'(overflow),   64'd0);
    check("t5_drop0",  64'(drop_cnt),   64'd0);
    check("t5_level",  64'(fifo_level), 64'd16);
    check("t5_head",   64'(trace_seq),  64'd35);
    check("t5_valid",  64'(trace_valid), 64'd1);

    // Reset mid-stream with 4 records queued discards them.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_ev(1'b1, 5'd2, 32'h900 + 32'(4 * i), 32'(i + 1));
      cycle();
    end
    check("t6_level4", 64'(fifo_level), 64'd4);
    check("t6_valid",  64'(trace_valid), 64'd1);
    rst = 1'b1;
    trace_ready = 1'b1;
    debug_wb_have_inst = 1'b1;
    cycle();
    rst = 1'b0;
    debug_wb_have_inst = 1'b0;
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    check("t6_rst_valid", 64'(trace_valid), 64'd0);
    check("t6_rst_level", 64'(fifo_level),  64'd0);
    check("t6_rst_fields", 64'({trace_seq, trace_reg} | 21'(trace_pc) | 21'(trace_value)), 64'd0);
    check("t6_rst_inst",  64'(inst_cnt),    64'd0);
    trace_ready = 1'b0;
    drive_ev(1'b1, 5'd6, 32'hA00, 32'hAA);
    cycle();
    check("t6_seq0", 64'(trace_seq), 64'd0);
    check("t6_pc",   64'(trace_pc),  64'hA00);

    // capture_en low: nothing captured or counted, queue still drains.
    capture_en = 1'b0;
    debug_wb_have_inst = 1'b1;
    drive_ev(1'b1, 5'd6, 32'hB00, 32'hBB);
    trace_ready = 1'b1;
    cycle();
    check("t7_level", 64'(fifo_level), 64'd0);
    check("t7_inst",  64'(inst_cnt),   64'd0);
    capture_en = 1'b1;
    debug_wb_have_inst = 1'b0;
    drive_ev(1'b1, 5'd6, 32'hC00, 32'hCC);
    cycle();
    drive_ev(1'b0, 5'd0, 32'd0, 32'd0);
    check("t7_seq1", 64'(trace_seq), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
